store_buffer: RTL and testbench

Posted-write buffer between the CPU memory stage and the data memory. Stores are captured into a small in-order FIFO in one cycle and drained to memory one per cycle whenever the CPU is not using the shared memory address port. Loads go straight to memory, or are served from the youngest matching buffered store. The FIFO is parameterised; all CPU-side and memory-side ports are word-addressed through `Address[31:2]`.

---
 rtl/store_buffer_pkg.sv | 14 +
 rtl/store_buffer_if.sv | 27 ++
 rtl/store_buffer_match.sv | 29 ++
 rtl/store_buffer.sv | 102 ++++++++++
 tb/tb_store_buffer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store_buffer posted-write FIFO.
package store_buffer_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;
    localparam int SB_ADDR_W        = 30;
    localparam int SB_DATA_W        = 32;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
        logic                 valid;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// CPU-side and memory-side signal bundle of the store buffer.
interface store_buffer_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       Address;
    logic [DATA_W-1:0] WriteData;
    logic              MemWrite;
    logic              MemRead;
    logic [DATA_W-1:0] ReadData;
    logic              Stall;
    logic              Empty;
    logic [31:0]       MemAddress;
    logic [DATA_W-1:0] MemWriteData;
    logic              MemWriteEn;
    logic              MemReadEn;
    logic [DATA_W-1:0] MemReadData;

    modport slave (
        input  Address, WriteData, MemWrite, MemRead, MemReadData,
        output ReadData, Stall, Empty, MemAddress, MemWriteData, MemWriteEn, MemReadEn
    );

    modport master (
        output Address, WriteData, MemWrite, MemRead, MemReadData,
        input  ReadData, Stall, Empty, MemAddress, MemWriteData, MemWriteEn, MemReadEn
    );
endinterface

// File: rtl/store_buffer_match.sv
// Load-address match across all buffered entries; reports the youngest hit.
module store_buffer_match
    import store_buffer_pkg::*;
#(
    parameter  int DEPTH = SB_DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0] entries,
    input  logic [PTR_W-1:0]      tail,
    input  logic [SB_ADDR_W-1:0]  addr,
    output logic                  hit,
    output logic [SB_DATA_W-1:0]  data
);

    // Walk from the slot at the tail (oldest) around to tail-1 (youngest);
    // later matches overwrite earlier ones, so the youngest wins.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[tail + PTR_W'(i)].valid && entries[tail + PTR_W'(i)].addr == addr) begin
                hit  = 1'b1;
                data = entries[tail + PTR_W'(i)].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// In-order posted-write buffer between CPU memory stage and data memory.
// Define STORE_BUFFER_FWD_EN to forward load hits; otherwise a hit stalls and drains.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH_DEFAULT,
    parameter int DATA_W = SB_DATA_W
) (
    input logic           clk,
    input logic           rst_n,
    store_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [SB_ADDR_W-1:0] addr_q [DEPTH];
    logic [SB_DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]     valid_q;
    sb_entry_t [DEPTH-1:0] entries;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic                 load;
    logic                 full;
    logic                 hit;
    logic                 hit_stall;
    logic                 drain;
    logic                 push;
    logic [SB_DATA_W-1:0] hit_data;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries[i] = '{addr: addr_q[i], data: data_q[i], valid: valid_q[i]};
        end
    end

    store_buffer_match #(.DEPTH(DEPTH)) u_match (
        .entries (entries),
        .tail    (tail),
        .addr    (bus.Address[31:2]),
        .hit     (hit),
        .data    (hit_data)
    );

    // A simultaneous store and load is treated as a store only.
    assign load = bus.MemRead && !bus.MemWrite;
    assign full = (count == CNT_W'(DEPTH));

`ifdef STORE_BUFFER_FWD_EN
    assign hit_stall = 1'b0;
`else
    assign hit_stall = load && hit;
`endif

    // Any MemRead owns the shared address port unless a hit forces the head out.
    assign drain = (!bus.MemRead && count != '0) || hit_stall;
    assign push  = bus.MemWrite && !bus.Stall;

    assign bus.Stall        = (bus.MemWrite && full) || hit_stall;
    assign bus.Empty        = (count == '0);
    assign bus.MemWriteEn   = drain;
    assign bus.MemAddress   = drain ? {addr_q[head], 2'b00} : bus.Address;
    assign bus.MemWriteData = DATA_W'(data_q[head]);
    assign bus.MemReadEn    = load && !hit;
    assign bus.ReadData     = !load ? '0 : (hit ? DATA_W'(hit_data) : bus.MemReadData);

    // NOTE: the address/data array has no reset; an entry is ignored until its valid bit is set.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= bus.Address[31:2];
            data_q[tail] <= SB_DATA_W'(bus.WriteData);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            if (drain) begin
                valid_q[head] <= 1'b0;
                head          <= head + PTR_W'(1);
            end
            if (push) begin
                valid_q[tail] <= 1'b1;
                tail          <= tail + PTR_W'(1);
            end
            case ({push, drain})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4) with a behavioural data memory.
`timescale 1ns/1ps
module tb_store_buffer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    store_buffer_if #(.DATA_W(32)) sb ();

    store_buffer #(.DEPTH(4), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sb)
    );

    // Word-indexed memory; unwritten words read as 0x1000_0000 + word index.
    logic [31:0] mem [64];
    logic [63:0] written = '0;
    logic [5:0]  midx;
    assign midx = sb.MemAddress[7:2];
    assign sb.MemReadData = written[midx] ? mem[midx] : (32'h1000_0000 | 32'(midx));

    always @(posedge clk) begin
        if (sb.MemWriteEn) begin
            mem[midx]     <= sb.MemWriteData;
            written[midx] <= 1'b1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        sb.MemWrite  = w;
        sb.MemRead   = r;
        sb.Address   = a;
        sb.WriteData = d;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h10, 32'h0);
        tick;
        check("rst_empty", 32'(sb.Empty), 32'd1);
        check("rst_stall", 32'(sb.Stall), 32'd0);
        check("rst_we",    32'(sb.MemWriteEn), 32'd0);
        check("rst_re",    32'(sb.MemReadEn), 32'd0);
        check("rst_rd",    sb.ReadData, 32'h0);
        check("rst_maddr", sb.MemAddress, 32'h10);
        rst_n = 1'b1;

        // Single store, then drain on the following idle cycle
        drive(1'b1, 1'b0, 32'h20, 32'hAAAA5555);
        check("a_stall", 32'(sb.Stall), 32'd0);
        check("a_we0",   32'(sb.MemWriteEn), 32'd0);
        tick;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        check("a_we",     32'(sb.MemWriteEn), 32'd1);
        check("a_maddr",  sb.MemAddress, 32'h20);
        check("a_mwd",    sb.MemWriteData, 32'hAAAA5555);
        check("a_empty0", 32'(sb.Empty), 32'd0);
        tick;
        check("a_empty1", 32'(sb.Empty), 32'd1);
        check("a_we_off", 32'(sb.MemWriteEn), 32'd0);
        drive(1'b0, 1'b1, 32'h20, 32'h0);
        check("a_re", 32'(sb.MemReadEn), 32'd1);
        check("a_rd", sb.ReadData, 32'hAAAA5555);
        tick;

        // Five back-to-back stores: from the second on, one entry drains per cycle
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 32'h80 + 4 * i, 32'hB000_0000 + i);
            check($sformatf("b_stall%0d", i), 32'(sb.Stall), 32'd0);
            check($sformatf("b_we%0d", i), 32'(sb.MemWriteEn), 32'(i > 0));
            if (i > 0) begin
                check($sformatf("b_maddr%0d", i), sb.MemAddress, 32'h80 + 4 * (i - 1));
                check($sformatf("b_mwd%0d", i), sb.MemWriteData, 32'hB000_0000 + (i - 1));
            end
            tick;
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        check("b_we_last",    32'(sb.MemWriteEn), 32'd1);
        check("b_maddr_last", sb.MemAddress, 32'h90);
        tick;
        check("b_empty", 32'(sb.Empty), 32'd1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 32'h80 + 4 * i, 32'h0);
            check($sformatf("b_mem%0d", i), sb.ReadData, 32'hB000_0000 + i);
            tick;
        end

        // Fill with MemRead held high: nothing drains, the fifth store stalls
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'hC0 + 4 * i, 32'hC000_0000 + i);
            check($sformatf("c_stall%0d", i), 32'(sb.Stall), 32'd0);
            check($sformatf("c_we%0d", i), 32'(sb.MemWriteEn), 32'd0);
            check($sformatf("c_re%0d", i), 32'(sb.MemReadEn), 32'd0);
            check($sformatf("c_rd%0d", i), sb.ReadData, 32'h0);
            tick;
        end
        drive(1'b1, 1'b1, 32'hD0, 32'hC000_0004);
        check("c_full_stall", 32'(sb.Stall), 32'd1);
        tick;
        check("c_full_hold", 32'(sb.Stall), 32'd1);
        drive(1'b1, 1'b0, 32'hD0, 32'hC000_0004);
        check("c_drain_stall", 32'(sb.Stall), 32'd1);
        check("c_drain_we",    32'(sb.MemWriteEn), 32'd1);
        check("c_drain_addr",  sb.MemAddress, 32'hC0);
        tick;
        check("c_accept_stall", 32'(sb.Stall), 32'd0);
        check("c_accept_addr",  sb.MemAddress, 32'hC4);
        tick;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        for (int j = 0; j < 3; j++) begin
            check($sformatf("c_tail_we%0d", j), 32'(sb.MemWriteEn), 32'd1);
            check($sformatf("c_tail_addr%0d", j), sb.MemAddress, 32'hC8 + 4 * j);
            tick;
        end
        check("c_empty", 32'(sb.Empty), 32'd1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 32'hC0 + 4 * i, 32'h0);
            check($sformatf("c_mem%0d", i), sb.ReadData, 32'hC000_0000 + i);
            tick;
        end

        // Two stores to the same word, then a load of that word
        drive(1'b1, 1'b1, 32'h40, 32'h1);
        tick;
        drive(1'b1, 1'b1, 32'h40, 32'h2);
        tick;
        drive(1'b0, 1'b1, 32'h42, 32'h0);
`ifdef STORE_BUFFER_FWD_EN
        check("d_rd",    sb.ReadData, 32'h2);
        check("d_re",    32'(sb.MemReadEn), 32'd0);
        check("d_stall", 32'(sb.Stall), 32'd0);
        check("d_maddr", sb.MemAddress, 32'h42);
        tick;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        check("d_mwd0", sb.MemWriteData, 32'h1);
        tick;
        check("d_mwd1", sb.MemWriteData, 32'h2);
        tick;
`else
        check("d_stall0", 32'(sb.Stall), 32'd1);
        check("d_re0",    32'(sb.MemReadEn), 32'd0);
        check("d_we0",    32'(sb.MemWriteEn), 32'd1);
        check("d_maddr0", sb.MemAddress, 32'h40);
        check("d_mwd0",   sb.MemWriteData, 32'h1);
        tick;
        check("d_stall1", 32'(sb.Stall), 32'd1);
        check("d_mwd1",   sb.MemWriteData, 32'h2);
        tick;
        check("d_stall2", 32'(sb.Stall), 32'd0);
        check("d_re2",    32'(sb.MemReadEn), 32'd1);
        check("d_rd2",    sb.ReadData, 32'h2);
        tick;
`endif
        check("d_empty", 32'(sb.Empty), 32'd1);
        drive(1'b0, 1'b1, 32'h40, 32'h0);
        check("d_mem", sb.ReadData, 32'h2);
        tick;

        // Reset asserted mid-drain with three entries buffered
        drive(1'b1, 1'b1, 32'h10, 32'hDEAD_0001);
        tick;
        drive(1'b1, 1'b1, 32'h14, 32'hDEAD_0002);
        tick;
        drive(1'b1, 1'b1, 32'h18, 32'hDEAD_0003);
        tick;
        drive(1'b0, 1'b0, 32'h3C, 32'h0);
        check("e_pre_we",    32'(sb.MemWriteEn), 32'd1);
        check("e_pre_maddr", sb.MemAddress, 32'h10);
        rst_n = 1'b0;
        #1;
        check("e_empty", 32'(sb.Empty), 32'd1);
        check("e_we",    32'(sb.MemWriteEn), 32'd0);
        check("e_stall", 32'(sb.Stall), 32'd0);
        check("e_maddr", sb.MemAddress, 32'h3C);
        tick;
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 32'h10, 32'h0);
        check("e_re",   32'(sb.MemReadEn), 32'd1);
        check("e_rd",   sb.ReadData, 32'h1000_0004);
        check("e_idle", 32'(sb.Empty), 32'd1);
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
